// File: rtl/vx_mem_line_serdes_pkg.sv
// Shared types and width helpers for the line-to-word serializer.
package vx_mem_line_serdes_pkg;

   localparam int unsigned LINE_W_DFLT = 512;
   localparam int unsigned WORD_W_DFLT = 32;
   localparam int unsigned ADDR_W_DFLT = 26;
   localparam int unsigned TAG_W_DFLT  = 8;
   localparam int unsigned BUS_AW_DFLT = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RSP   = 2'd3
   } state_t;

   // Number of bus words per line.
   function automatic int unsigned f_beats(input int unsigned line_w, input int unsigned word_w);
      return line_w / word_w;
   endfunction

   // Beat counter width, never below one bit.
   function automatic int unsigned f_beat_w(input int unsigned beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   // Bytes per bus word.
   function automatic int unsigned f_word_bytes(input int unsigned word_w);
      return word_w / 8;
   endfunction

endpackage

// File: rtl/vx_mem_line_serdes_if.sv
// Line request/response port plus the single-word bus, bundled together.
// master: request source, response sink and bus target. slave: the serdes.
interface vx_mem_line_serdes_if
   import vx_mem_line_serdes_pkg::*;
#(
   parameter int unsigned LINE_W = LINE_W_DFLT,
   parameter int unsigned WORD_W = WORD_W_DFLT,
   parameter int unsigned ADDR_W = ADDR_W_DFLT,
   parameter int unsigned TAG_W  = TAG_W_DFLT,
   parameter int unsigned BUS_AW = BUS_AW_DFLT
) ();

   logic                  mem_req_valid;
   logic                  mem_req_rw;
   logic [LINE_W/8-1:0]   mem_req_byteen;
   logic [ADDR_W-1:0]     mem_req_addr;
   logic [LINE_W-1:0]     mem_req_data;
   logic [TAG_W-1:0]      mem_req_tag;
   logic                  mem_req_ready;

   logic                  mem_rsp_valid;
   logic [LINE_W-1:0]     mem_rsp_data;
   logic [TAG_W-1:0]      mem_rsp_tag;
   logic                  mem_rsp_ready;

   logic [BUS_AW-1:0]     bus_addr;
   logic [WORD_W-1:0]     bus_wdata;
   logic [WORD_W/8-1:0]   bus_byte_en;
   logic                  bus_ren;
   logic                  bus_wen;
   logic                  bus_busy;
   logic [WORD_W-1:0]     bus_rdata;

   modport master (
      output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      output mem_rsp_ready,
      input  bus_addr, bus_wdata, bus_byte_en, bus_ren, bus_wen,
      output bus_busy, bus_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      input  mem_rsp_ready,
      output bus_addr, bus_wdata, bus_byte_en, bus_ren, bus_wen,
      input  bus_busy, bus_rdata
   );

endinterface

// File: rtl/vx_mem_line_serdes.sv
// Splits one cache-line request into word beats on a ren/wen/busy bus and
// gathers read beats back into a tagged line response. One request in flight.
// Optional build macro: VX_MEM_SERDES_SKIP_EMPTY_EN -- write beats with an
// all-zero byte-enable slice are skipped (strobe low, counter still advances).
module vx_mem_line_serdes
   import vx_mem_line_serdes_pkg::*;
#(
   parameter int unsigned LINE_W = LINE_W_DFLT,
   parameter int unsigned WORD_W = WORD_W_DFLT,
   parameter int unsigned ADDR_W = ADDR_W_DFLT,
   parameter int unsigned TAG_W  = TAG_W_DFLT,
   parameter int unsigned BUS_AW = BUS_AW_DFLT
) (
   input  logic                 clk,
   input  logic                 reset,
   vx_mem_line_serdes_if.slave  io,
   output logic                 busy
);

   localparam int unsigned BEATS      = f_beats(LINE_W, WORD_W);
   localparam int unsigned BEAT_W     = f_beat_w(BEATS);
   localparam int unsigned WORD_BYTES = f_word_bytes(WORD_W);
   localparam int unsigned OFF_W      = $clog2(WORD_BYTES);
   localparam int unsigned FULL_AW    = ADDR_W + BEAT_W + OFF_W;

   state_t                             r_state, w_nxt_state;
   logic [BEAT_W-1:0]                  r_beat, w_nxt_beat;

   logic [ADDR_W-1:0]                  r_addr;
   logic [TAG_W-1:0]                   r_tag;
   logic [BEATS-1:0][WORD_W-1:0]       r_wdata;
   logic [BEATS-1:0][WORD_BYTES-1:0]   r_byteen;
   logic [BEATS-1:0][WORD_W-1:0]       r_rdbuf;

   logic                               r_ready, r_busy, r_rsp_valid, r_ren, r_wen;
   logic [BUS_AW-1:0]                  r_bus_addr;
   logic [WORD_W-1:0]                  r_bus_wdata;
   logic [WORD_BYTES-1:0]              r_bus_byte_en;

   logic                               w_nxt_ready, w_nxt_busy, w_nxt_rsp_valid, w_nxt_ren, w_nxt_wen;
   logic [BUS_AW-1:0]                  w_nxt_bus_addr;
   logic [WORD_W-1:0]                  w_nxt_bus_wdata;
   logic [WORD_BYTES-1:0]              w_nxt_bus_byte_en;

   logic                               w_accept, w_last, w_skip, w_done;
   logic [ADDR_W-1:0]                  w_src_addr;
   logic [BEATS-1:0][WORD_W-1:0]       w_src_data;
   logic [BEATS-1:0][WORD_BYTES-1:0]   w_src_be;
   logic [FULL_AW-1:0]                 w_full_addr;

   assign w_accept = io.mem_req_valid & r_ready;
   assign w_last   = (r_beat == BEAT_W'(BEATS - 1));

`ifdef VX_MEM_SERDES_SKIP_EMPTY_EN
   assign w_skip = (r_state == WRITE) && (r_byteen[r_beat] == '0);
`else
   assign w_skip = 1'b0;
`endif

   // A beat finishes on an unstalled strobe, or immediately when it is skipped.
   assign w_done = ((r_ren | r_wen) & ~io.bus_busy) | w_skip;

   // Line fields feeding next-cycle bus outputs: fresh request on accept, else latched copy.
   assign w_src_addr = w_accept ? io.mem_req_addr   : r_addr;
   assign w_src_data = w_accept ? io.mem_req_data   : r_wdata;
   assign w_src_be   = w_accept ? io.mem_req_byteen : r_byteen;

   assign w_full_addr = {w_src_addr, w_nxt_beat, {OFF_W{1'b0}}};

   // State register and beat counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_beat  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_beat  <= w_nxt_beat;
      end
   end

   // Next state and beat; the counter holds at the last beat instead of wrapping.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_beat  = r_beat;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nxt_state = io.mem_req_rw ? WRITE : READ;
               w_nxt_beat  = '0;
            end
         end
         READ, WRITE: begin
            if (w_done) begin
               if (w_last) w_nxt_state = (r_state == READ) ? RSP : IDLE;
               else        w_nxt_beat  = r_beat + 1'b1;
            end
         end
         RSP: begin
            if (io.mem_rsp_ready) w_nxt_state = IDLE;
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // Output decode from the next state so every port comes straight from a flop.
   always_comb begin
      w_nxt_ready       = (w_nxt_state == IDLE);
      w_nxt_busy        = (w_nxt_state != IDLE);
      w_nxt_rsp_valid   = (w_nxt_state == RSP);
      w_nxt_ren         = (w_nxt_state == READ);
      w_nxt_wen         = (w_nxt_state == WRITE);
      w_nxt_bus_addr    = '0;
      w_nxt_bus_wdata   = '0;
      w_nxt_bus_byte_en = '0;
`ifdef VX_MEM_SERDES_SKIP_EMPTY_EN
      if (w_src_be[w_nxt_beat] == '0) w_nxt_wen = 1'b0;
`endif
      if ((w_nxt_state == READ) || (w_nxt_state == WRITE)) begin
         w_nxt_bus_addr    = BUS_AW'(w_full_addr);
         w_nxt_bus_wdata   = w_src_data[w_nxt_beat];
         w_nxt_bus_byte_en = w_src_be[w_nxt_beat];
      end
   end

   // Request capture on accept and read-word gather into the response line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr   <= '0;
         r_tag    <= '0;
         r_wdata  <= '0;
         r_byteen <= '0;
         r_rdbuf  <= '0;
      end else begin
         if (w_accept) begin
            r_addr   <= io.mem_req_addr;
            r_tag    <= io.mem_req_tag;
            r_wdata  <= io.mem_req_data;
            r_byteen <= io.mem_req_byteen;
         end
         if ((r_state == READ) && w_done) r_rdbuf[r_beat] <= io.bus_rdata;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready       <= 1'b1;
         r_busy        <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_ren         <= 1'b0;
         r_wen         <= 1'b0;
         r_bus_addr    <= '0;
         r_bus_wdata   <= '0;
         r_bus_byte_en <= '0;
      end else begin
         r_ready       <= w_nxt_ready;
         r_busy        <= w_nxt_busy;
         r_rsp_valid   <= w_nxt_rsp_valid;
         r_ren         <= w_nxt_ren;
         r_wen         <= w_nxt_wen;
         r_bus_addr    <= w_nxt_bus_addr;
         r_bus_wdata   <= w_nxt_bus_wdata;
         r_bus_byte_en <= w_nxt_bus_byte_en;
      end
   end

   assign io.mem_req_ready = r_ready;
   assign io.mem_rsp_valid = r_rsp_valid;
   assign io.mem_rsp_data  = r_rdbuf;
   assign io.mem_rsp_tag   = r_tag;
   assign io.bus_addr      = r_bus_addr;
   assign io.bus_wdata     = r_bus_wdata;
   assign io.bus_byte_en   = r_bus_byte_en;
   assign io.bus_ren       = r_ren;
   assign io.bus_wen       = r_wen;
   assign busy             = r_busy;

endmodule
